// File: rtl/spi_register_master_if.sv
// Request/response bus between a register-write client and spi_register_master.
// The client side uses modport master; the SPI engine uses modport slave.
interface spi_register_master_if;
  logic        i_Valid;
  logic        o_Ready;
  logic [15:0] i_RegisterNumber;
  logic [15:0] i_RegisterValue;
  logic        o_Done;
  logic [31:0] o_ReadData;

  modport master (
    output i_Valid,
    output i_RegisterNumber,
    output i_RegisterValue,
    input  o_Ready,
    input  o_Done,
    input  o_ReadData
  );

  modport slave (
    input  i_Valid,
    input  i_RegisterNumber,
    input  i_RegisterValue,
    output o_Ready,
    output o_Done,
    output o_ReadData
  );
endinterface

// File: rtl/spi_register_master.sv
// SPI mode-0 master that shifts out one 32-bit {number, value} register write
// per request and returns the 32 MISO bits captured during the frame.
module spi_register_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  spi_register_master_if.slave  bus,
  output logic                  o_SPI_NSS,
  output logic                  o_SPI_SCK,
  output logic                  o_SPI_MOSI,
  input  logic                  i_SPI_MISO
);

  localparam int HalfWidth = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [HalfWidth-1:0] HalfLast = HalfWidth'(CLK_DIV - 1);
  localparam logic [HalfWidth-1:0] HalfOne  = HalfWidth'(1);
  localparam logic [7:0]           GapLast  = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } stateType;

  stateType             state;
  stateType             stateNext;
  logic [HalfWidth-1:0] halfCount;
  logic [HalfWidth-1:0] halfNext;
  logic [5:0]           bitCount;
  logic [5:0]           bitNext;
  logic [7:0]           gapCount;
  logic [7:0]           gapNext;
  logic [31:0]          txShift;
  logic [31:0]          txNext;
  logic [31:0]          rxShift;
  logic [31:0]          rxNext;
  logic [31:0]          readData;
  logic [31:0]          readDataNext;
  logic                 sck;
  logic                 sckNext;
  logic                 nss;
  logic                 nssNext;
  logic                 done;
  logic                 doneNext;
  logic [1:0]           resetSync;
  logic                 ready;
  logic                 accept;
  logic                 halfEnd;

  // Reset release is synchronized; the engine may not accept until it clears.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      resetSync <= 2'b00;
    end else begin
      resetSync <= {resetSync[0], 1'b1};
    end
  end

  assign ready   = (state == IDLE) && resetSync[1];
  assign accept  = bus.i_Valid && ready;
  assign halfEnd = (halfCount == HalfLast);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= IDLE;
      halfCount <= '0;
      bitCount  <= '0;
      gapCount  <= '0;
      txShift   <= '0;
      rxShift   <= '0;
      readData  <= '0;
      sck       <= 1'b0;
      nss       <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      halfCount <= halfNext;
      bitCount  <= bitNext;
      gapCount  <= gapNext;
      txShift   <= txNext;
      rxShift   <= rxNext;
      readData  <= readDataNext;
      sck       <= sckNext;
      nss       <= nssNext;
      done      <= doneNext;
    end
  end

  // SHIFT alternates SCK every half period: high edges sample MISO,
  // low edges advance MOSI and count bits.
  always_comb begin
    stateNext    = state;
    halfNext     = halfCount;
    bitNext      = bitCount;
    gapNext      = gapCount;
    txNext       = txShift;
    rxNext       = rxShift;
    readDataNext = readData;
    sckNext      = sck;
    nssNext      = nss;
    doneNext     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = SETUP;
          halfNext  = '0;
          bitNext   = '0;
          gapNext   = '0;
          txNext    = {bus.i_RegisterNumber, bus.i_RegisterValue};
          rxNext    = '0;
          nssNext   = 1'b0;
          sckNext   = 1'b0;
        end
      end

      SETUP: begin
        if (halfEnd) begin
          stateNext = SHIFT;
          halfNext  = '0;
          sckNext   = 1'b1;
          rxNext    = {rxShift[30:0], i_SPI_MISO};
        end else begin
          halfNext = halfCount + HalfOne;
        end
      end

      SHIFT: begin
        if (halfEnd) begin
          halfNext = '0;
          if (!sck) begin
            sckNext = 1'b1;
            rxNext  = {rxShift[30:0], i_SPI_MISO};
          end else begin
            sckNext = 1'b0;
            txNext  = {txShift[30:0], 1'b0};
            bitNext = bitCount + 6'd1;
            if (bitCount == 6'd31) begin
              stateNext = HOLD;
            end
          end
        end else begin
          halfNext = halfCount + HalfOne;
        end
      end

      HOLD: begin
        if (halfEnd) begin
          stateNext    = GAP;
          halfNext     = '0;
          gapNext      = '0;
          nssNext      = 1'b1;
          doneNext     = 1'b1;
          readDataNext = rxShift;
        end else begin
          halfNext = halfCount + HalfOne;
        end
      end

      GAP: begin
        if (gapCount == GapLast) begin
          stateNext = IDLE;
          gapNext   = '0;
        end else begin
          gapNext = gapCount + 8'd1;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign bus.o_Ready      = ready;
  assign bus.o_Done       = done;
  assign bus.o_ReadData   = readData;
  assign o_SPI_NSS        = nss;
  assign o_SPI_SCK        = sck & ~nss;
  assign o_SPI_MOSI       = txShift[31] & ~nss;

endmodule

// File: tb/tb_spi_register_master.sv
// Self-checking bench for spi_register_master: a table of known frames, random
// frames against a frame-level model, and hand-written multi-cycle corner cases.
module tb_spi_register_master;

  localparam int DivA = 4;
  localparam int GapA = 8;
  localparam int DivB = 2;
  localparam int GapB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetA_n;
  logic resetB_n;
  logic nssA, sckA, mosiA, misoA;
  logic nssB, sckB, mosiB, misoB;

  spi_register_master_if busA ();
  spi_register_master_if busB ();

  spi_register_master #(.CLK_DIV(DivA), .GAP_CYCLES(GapA)) dutA (
    .i_Clock    (clk),
    .i_Reset_n  (resetA_n),
    .bus        (busA),
    .o_SPI_NSS  (nssA),
    .o_SPI_SCK  (sckA),
    .o_SPI_MOSI (mosiA),
    .i_SPI_MISO (misoA)
  );

  spi_register_master #(.CLK_DIV(DivB), .GAP_CYCLES(GapB)) dutB (
    .i_Clock    (clk),
    .i_Reset_n  (resetB_n),
    .bus        (busB),
    .o_SPI_NSS  (nssB),
    .o_SPI_SCK  (sckB),
    .o_SPI_MOSI (mosiB),
    .i_SPI_MISO (misoB)
  );

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int total = 0;
  int bad   = 0;

  // Slave model A: drives MISO from a pattern MSB first, records MOSI on SCK rise.
  logic [31:0] misoPatA = '0;
  logic [31:0] capA = '0;
  int riseCntA = 0, lastRisesA = 0, fallCountA = 0, lastFallA = 0;
  int doneCountA = 0, lastDoneA = 0, lastReadyA = 0, errA = 0;
  logic prevNssA = 1'b1, prevSckA = 1'b0, prevMosiA = 1'b0, prevDoneA = 1'b0, prevReadyA = 1'b0;

  assign misoA = (riseCntA < 32) ? misoPatA[5'(31 - riseCntA)] : 1'b0;

  always @(negedge clk) begin
    prevNssA   <= nssA;
    prevSckA   <= sckA;
    prevMosiA  <= mosiA;
    prevDoneA  <= busA.o_Done;
    prevReadyA <= busA.o_Ready;
    errA <= errA + int'(sckA && prevSckA && (mosiA != prevMosiA))
                 + int'(nssA && (sckA || mosiA))
                 + int'(busA.o_Done && prevDoneA);
    if (!nssA && prevNssA) begin
      fallCountA <= fallCountA + 1;
      lastFallA  <= cycle;
      capA       <= '0;
    end
    if (nssA && !prevNssA) lastRisesA <= riseCntA;
    if (nssA) begin
      riseCntA <= 0;
    end else if (sckA && !prevSckA) begin
      capA     <= {capA[30:0], mosiA};
      riseCntA <= riseCntA + 1;
    end
    if (busA.o_Done) begin
      doneCountA <= doneCountA + 1;
      lastDoneA  <= cycle;
    end
    if (busA.o_Ready && !prevReadyA) lastReadyA <= cycle;
  end

  // Slave model B, same behaviour for the fast-SCK instance.
  logic [31:0] misoPatB = '0;
  logic [31:0] capB = '0;
  int riseCntB = 0, lastRisesB = 0, doneCountB = 0, lastDoneB = 0, lastReadyB = 0, errB = 0;
  logic prevNssB = 1'b1, prevSckB = 1'b0, prevMosiB = 1'b0, prevDoneB = 1'b0, prevReadyB = 1'b0;

  assign misoB = (riseCntB < 32) ? misoPatB[5'(31 - riseCntB)] : 1'b0;

  always @(negedge clk) begin
    prevNssB   <= nssB;
    prevSckB   <= sckB;
    prevMosiB  <= mosiB;
    prevDoneB  <= busB.o_Done;
    prevReadyB <= busB.o_Ready;
    errB <= errB + int'(sckB && prevSckB && (mosiB != prevMosiB))
                 + int'(nssB && (sckB || mosiB))
                 + int'(busB.o_Done && prevDoneB);
    if (!nssB && prevNssB) capB <= '0;
    if (nssB && !prevNssB) lastRisesB <= riseCntB;
    if (nssB) begin
      riseCntB <= 0;
    end else if (sckB && !prevSckB) begin
      capB     <= {capB[30:0], mosiB};
      riseCntB <= riseCntB + 1;
    end
    if (busB.o_Done) begin
      doneCountB <= doneCountB + 1;
      lastDoneB  <= cycle;
    end
    if (busB.o_Ready && !prevReadyB) lastReadyB <= cycle;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit useB, input logic [15:0] num, input logic [15:0] val,
                               input logic [31:0] pattern, input bit hold, output int acceptCycle);
    bit accepted;
    accepted    = 1'b0;
    acceptCycle = -1;
    if (useB) begin
      misoPatB = pattern;
      busB.i_RegisterNumber = num;
      busB.i_RegisterValue  = val;
      busB.i_Valid = 1'b1;
    end else begin
      misoPatA = pattern;
      busA.i_RegisterNumber = num;
      busA.i_RegisterValue  = val;
      busA.i_Valid = 1'b1;
    end
    for (int i = 0; i < 100 && !accepted; i++) begin
      if (useB ? busB.o_Ready : busA.o_Ready) begin
        acceptCycle = cycle + 1;
        accepted    = 1'b1;
      end
      tick();
    end
    if (!hold) begin
      if (useB) busB.i_Valid = 1'b0;
      else      busA.i_Valid = 1'b0;
    end
    if (!accepted) checkOutput("accept timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDone(input bit useB, input int startCount);
    int n;
    n = 0;
    while (((useB ? doneCountB : doneCountA) == startCount) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) checkOutput("done timeout", 32'd0, 32'd1);
  endtask

  task automatic waitReady(input bit useB);
    int n;
    n = 0;
    while (!(useB ? busB.o_Ready : busA.o_Ready) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) checkOutput("ready timeout", 32'd0, 32'd1);
    @(negedge clk);
    #1;
  endtask

  // Frame-level model: MOSI carries {number, value}, ReadData returns the MISO
  // pattern, Done lands 65 half periods after accept and Ready GAP cycles later.
  task automatic runFrame(input bit useB, input logic [15:0] num, input logic [15:0] val,
                          input logic [31:0] pattern, input logic [31:0] expWord,
                          input logic [31:0] expRead, input string tag);
    int startDone, acc, div, gap;
    logic [31:0] cap, rd;
    int dn, rdy, rises;
    div       = useB ? DivB : DivA;
    gap       = useB ? GapB : GapA;
    startDone = useB ? doneCountB : doneCountA;
    applyStimulus(useB, num, val, pattern, 1'b0, acc);
    waitDone(useB, startDone);
    waitReady(useB);
    cap   = useB ? capB : capA;
    rd    = useB ? busB.o_ReadData : busA.o_ReadData;
    dn    = useB ? lastDoneB : lastDoneA;
    rdy   = useB ? lastReadyB : lastReadyA;
    rises = useB ? lastRisesB : lastRisesA;
    checkOutput($sformatf("%s mosi word", tag), cap, expWord);
    checkOutput($sformatf("%s readData", tag), rd, expRead);
    checkOutput($sformatf("%s done offset", tag), 32'(dn - acc), 32'(65 * div));
    checkOutput($sformatf("%s ready offset", tag), 32'(rdy - acc), 32'(65 * div + gap));
    checkOutput($sformatf("%s sck rises", tag), 32'(rises), 32'd32);
  endtask

  typedef struct {
    logic [15:0] num;
    logic [15:0] val;
    logic [31:0] pattern;
    logic [31:0] expWord;
    logic [31:0] expRead;
  } vectorType;

  vectorType vectors [4];

  initial begin
    int acc1, acc2, sd, fc;
    logic [15:0] n1, v1, n2, v2;
    logic [31:0] pat;

    vectors[0] = '{16'hC123, 16'hBEEF, 32'h12345678, 32'hC123BEEF, 32'h12345678};
    vectors[1] = '{16'h0000, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vectors[2] = '{16'hFFFF, 16'hFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vectors[3] = '{16'hA5A5, 16'h5A5A, 32'h80000001, 32'hA5A55A5A, 32'h80000001};

    resetA_n = 1'b0;
    resetB_n = 1'b0;
    busA.i_Valid = 1'b0; busA.i_RegisterNumber = '0; busA.i_RegisterValue = '0;
    busB.i_Valid = 1'b0; busB.i_RegisterNumber = '0; busB.i_RegisterValue = '0;
    repeat (3) tick();

    checkOutput("reset nss", 32'(nssA), 32'd1);
    checkOutput("reset sck", 32'(sckA), 32'd0);
    checkOutput("reset mosi", 32'(mosiA), 32'd0);
    checkOutput("reset ready", 32'(busA.o_Ready), 32'd0);
    checkOutput("reset done", 32'(busA.o_Done), 32'd0);
    checkOutput("reset readData", busA.o_ReadData, 32'd0);

    resetA_n = 1'b1;
    resetB_n = 1'b1;
    tick();
    tick();
    checkOutput("ready after reset A", 32'(busA.o_Ready), 32'd1);
    checkOutput("ready after reset B", 32'(busB.o_Ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      runFrame(1'b0, vectors[i].num, vectors[i].val, vectors[i].pattern,
               vectors[i].expWord, vectors[i].expRead, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      n1  = 16'($urandom);
      v1  = 16'($urandom);
      pat = $urandom;
      runFrame(1'b0, n1, v1, pat, {n1, v1}, pat, $sformatf("rand%0d", i));
    end

    // Back-to-back frames with Valid held; data changed while busy must wait.
    n1 = 16'h1357; v1 = 16'h2468; n2 = 16'h9ABC; v2 = 16'hDEF0; pat = 32'hCAFEF00D;
    sd = doneCountA;
    applyStimulus(1'b0, n1, v1, pat, 1'b1, acc1);
    busA.i_RegisterNumber = n2;
    busA.i_RegisterValue  = v2;
    waitDone(1'b0, sd);
    tick();
    checkOutput("b2b first word", capA, {n1, v1});
    acc2 = -1;
    for (int i = 0; i < 100 && acc2 < 0; i++) begin
      if (busA.o_Ready) acc2 = cycle + 1;
      tick();
    end
    busA.i_Valid = 1'b0;
    checkOutput("b2b period", 32'(acc2 - acc1), 32'(65 * DivA + GapA + 1));
    @(negedge clk);
    #1;
    checkOutput("b2b nss high cycles", 32'(lastFallA - lastDoneA), 32'(GapA + 1));
    sd = doneCountA;
    waitDone(1'b0, sd);
    waitReady(1'b0);
    checkOutput("b2b second word", capA, {n2, v2});
    checkOutput("b2b second readData", busA.o_ReadData, pat);

    // Valid pulsed mid-frame with other data: ignored, nothing queued.
    sd = doneCountA;
    applyStimulus(1'b0, 16'h4242, 16'h0F0F, 32'h0BADBEEF, 1'b0, acc1);
    while (cycle < acc1 + 40) tick();
    busA.i_RegisterNumber = 16'hFFFF;
    busA.i_RegisterValue  = 16'h0000;
    busA.i_Valid = 1'b1;
    repeat (6) tick();
    busA.i_Valid = 1'b0;
    waitDone(1'b0, sd);
    tick();
    checkOutput("midframe valid word", capA, 32'h42420F0F);
    fc = fallCountA;
    repeat (300) tick();
    checkOutput("midframe no extra frame", 32'(fallCountA), 32'(fc));

    // Reset 100 cycles into a frame (SCK just went high): async abort.
    sd = doneCountA;
    applyStimulus(1'b0, 16'h7777, 16'h8888, 32'h55AA55AA, 1'b0, acc1);
    while (cycle < acc1 + 100) tick();
    #2;
    resetA_n = 1'b0;
    #1;
    checkOutput("abort nss", 32'(nssA), 32'd1);
    checkOutput("abort sck", 32'(sckA), 32'd0);
    checkOutput("abort ready", 32'(busA.o_Ready), 32'd0);
    checkOutput("abort readData", busA.o_ReadData, 32'd0);
    repeat (3) tick();
    resetA_n = 1'b1;
    tick();
    tick();
    checkOutput("abort no done", 32'(doneCountA), 32'(sd));
    checkOutput("abort ready after release", 32'(busA.o_Ready), 32'd1);
    checkOutput("abort readData after release", busA.o_ReadData, 32'd0);
    runFrame(1'b0, 16'hC123, 16'hBEEF, 32'h12345678, 32'hC123BEEF, 32'h12345678, "post-reset");

    // Fastest SCK, MISO tied high then low.
    n1 = 16'($urandom); v1 = 16'($urandom);
    runFrame(1'b1, n1, v1, 32'hFFFFFFFF, {n1, v1}, 32'hFFFFFFFF, "fast miso1");
    n1 = 16'($urandom); v1 = 16'($urandom);
    runFrame(1'b1, n1, v1, 32'h00000000, {n1, v1}, 32'h00000000, "fast miso0");

    checkOutput("protocol errors A", 32'(errA), 32'd0);
    checkOutput("protocol errors B", 32'(errB), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
